gmii_tx_framer: RTL
===================

GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12: txen-low cycles inserted after each frame.
REQ-002 SHALL have parameter MIN_FRAME, default 60: minimum bytes before FCS; shorter frames are zero-padded.
REQ-003 SHALL have port clock_clk, input, 1: the only clock, 125 MHz GMII transmit clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports in_data (input, 8), in_valid (input, 1), in_ready (output, 1), in_startofpacket (input, 1), in_endofpacket (input, 1), in_error (input, 1): Avalon-ST byte sink.
REQ-006 SHALL have port gmii_txd, output, 8: GMII transmit data, registered.
REQ-007 SHALL have port gmii_txen, output, 1: GMII transmit enable, registered.
REQ-008 SHALL have port gmii_txer, output, 1: GMII transmit error, registered.
REQ-009 SHALL have port tx_busy, output, 1: high in any state other than IDLE.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse on the last FCS byte.

Function
REQ-011 SHALL implement FSM states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
REQ-012 IDLE: in_valid=1 and in_startofpacket=1 at cycle N SHALL move to PREAMBLE without consuming the beat; gmii_txen=1, gmii_txd=0x55 on cycles N+1..N+7; 0xD5 on N+8; first payload byte on N+9.
REQ-013 IDLE: a beat with in_valid=1 and in_startofpacket=0 SHALL be consumed (in_ready=1) and discarded with no GMII activity.
REQ-014 in_ready SHALL be high exactly on cycles where an accepted beat drives gmii_txd on the next cycle; a beat accepted at cycle t SHALL appear on gmii_txd at t+1.
REQ-015 In DATA, in_startofpacket SHALL be ignored; in_endofpacket on an accepted beat SHALL end the payload, and in_ready SHALL drop the following cycle.
REQ-016 Underrun, meaning in_ready=1 and in_valid=0 in DATA: the next cycle SHALL drive gmii_txd=0x00, gmii_txen=1, gmii_txer=1, and count the slot as a payload byte included in the CRC; the frame SHALL continue.
REQ-017 An accepted beat with in_error=1 SHALL be sent with gmii_txer=1 on its cycle.
REQ-018 gmii_txer SHALL be 0 on all other cycles.
REQ-019 Byte counter SHALL be 11 bits, saturating at 2047, cleared at SFD, and counting payload plus pad bytes.
REQ-020 On end of payload with count < MIN_FRAME, PAD SHALL emit 0x00 until count = MIN_FRAME; otherwise FSM SHALL go directly to FCS.
REQ-021 CRC SHALL be IEEE 802.3 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) over payload and pad, excluding preamble and SFD.
REQ-022 FCS SHALL emit 4 bytes, least-significant byte first, with frame_done=1 on the 4th byte.
REQ-023 IFG SHALL hold gmii_txen=0, gmii_txd=0x00, in_ready=0 for exactly IFG_BYTES cycles, then enter IDLE.
REQ-024 An SOP waiting during IFG SHALL start preamble on the cycle after IDLE is entered, giving a gap of IFG_BYTES+1 cycles.
REQ-025 Total gmii_txen-high cycles per frame SHALL equal 8 + max(payload, MIN_FRAME) + 4.

Reset
REQ-026 When reset_reset=1 at a clock edge, the next cycle SHALL have state IDLE, gmii_txd=0x00, gmii_txen=0, gmii_txer=0, in_ready=0, tx_busy=0, frame_done=0, counter=0, CRC=0xFFFFFFFF.
REQ-027 Reset mid-frame SHALL truncate the frame immediately with no FCS or IFG; the next SOP after reset release SHALL begin with a full preamble.
REQ-028 in_ready SHALL be 0 while reset_reset=1.

Verification
REQ-029 100-byte frame of incrementing data 0x00..0x63 -> txen high 112 cycles: 7x0x55, 0xD5, 100 data bytes, FCS matching the reference CRC model; then exactly 12 txen-low cycles.
REQ-030 1-byte frame 0xAB -> 0xAB followed by 59 bytes of 0x00, FCS over those 60 bytes, txen high 72 cycles, frame_done pulses once.
REQ-031 in_valid dropped for 1 cycle at payload byte 20 of a 64-byte frame -> exactly one cycle with txer=1 and txd=0x00; 65 payload slots precede the FCS.
REQ-032 Two frames with the second SOP held during the first frame's FCS -> exactly 13 txen-low cycles between frames.
REQ-033 reset_reset pulsed during payload byte 30 -> txen=0 and in_ready=0 on the next cycle; the following frame is correct and complete.
REQ-034 3 non-SOP beats presented in IDLE -> all accepted, txen stays 0, tx_busy stays 0.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps an Avalon-ST byte stream in preamble/SFD, pads short
// frames, appends the IEEE 802.3 CRC-32 FCS and enforces the inter-frame gap.
module gmii_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic       clock_clk,
  input  logic       reset_reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  input  logic       in_error,
  output logic [7:0] gmii_txd,
  output logic       gmii_txen,
  output logic       gmii_txer,
  output logic       tx_busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] sub_q, sub_d;
  logic [7:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        txer_q, txer_d;
  logic        done_q, done_d;
  logic [31:0] fcs;
  logic [7:0]  acc_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [10:0] sat_inc(input logic [10:0] c);
    return (c == 11'h7FF) ? c : c + 11'd1;
  endfunction

  assign fcs      = ~crc_q;
  assign acc_byte = in_valid ? in_data : 8'h00;

  // Outputs are registered alongside the state, so state_q names the decision
  // being made for the byte that appears on GMII in the following cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    sub_d   = sub_q;
    txd_d   = 8'h00;
    txen_d  = 1'b0;
    txer_d  = 1'b0;
    done_d  = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = in_valid && !in_startofpacket;
        if (in_valid && in_startofpacket) begin
          state_d = S_PREAMBLE;
          txd_d   = 8'h55;
          txen_d  = 1'b1;
          sub_d   = 16'd1;
        end
      end
      S_PREAMBLE: begin
        txen_d = 1'b1;
        if (sub_q == 16'd7) begin
          state_d = S_SFD;
          txd_d   = 8'hD5;
          cnt_d   = 11'd0;
          crc_d   = 32'hFFFFFFFF;
        end else begin
          txd_d = 8'h55;
          sub_d = sub_q + 16'd1;
        end
      end
      S_SFD, S_DATA: begin
        // A missing beat still occupies a payload slot, flagged as an error.
        in_ready = 1'b1;
        txd_d    = acc_byte;
        txen_d   = 1'b1;
        txer_d   = in_valid ? in_error : 1'b1;
        cnt_d    = sat_inc(cnt_q);
        crc_d    = crc_byte(crc_q, acc_byte);
        state_d  = S_DATA;
        if (in_valid && in_endofpacket) begin
          state_d = (sat_inc(cnt_q) < MIN_CNT) ? S_PAD : S_FCS;
          sub_d   = 16'd0;
        end
      end
      S_PAD: begin
        txen_d = 1'b1;
        cnt_d  = sat_inc(cnt_q);
        crc_d  = crc_byte(crc_q, 8'h00);
        if (sat_inc(cnt_q) >= MIN_CNT) begin
          state_d = S_FCS;
          sub_d   = 16'd0;
        end
      end
      S_FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs[{sub_q[1:0], 3'b000} +: 8];
        if (sub_q[1:0] == 2'd3) begin
          done_d  = 1'b1;
          state_d = S_IFG;
          sub_d   = 16'd0;
        end else begin
          sub_d = sub_q + 16'd1;
        end
      end
      S_IFG: begin
        if (sub_q == IFG_LAST) begin
          state_d = S_IDLE;
        end else begin
          sub_d = sub_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset_reset) in_ready = 1'b0;
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 11'd0;
      crc_q   <= 32'hFFFFFFFF;
      sub_q   <= 16'd0;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      txer_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      sub_q   <= sub_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      txer_q  <= txer_d;
      done_q  <= done_d;
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_txen  = txen_q;
  assign gmii_txer  = txer_q;
  assign frame_done = done_q;
  assign tx_busy    = (state_q != S_IDLE);

endmodule
